// File: rtl/regfile_bypass.sv
// Eight-entry register file with two combinational read ports and one write port.
// Optional same-cycle write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.

module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             err_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

  // Flags unresolved control/data so the file-level err can report it.
  always_comb begin
    err_o = $isunknown({clk_i, rst_i, en_i, d_i});
  end

endmodule

module regfile_bypass #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read1_reg,
  input  logic [AW-1:0]    read2_reg,
  input  logic [AW-1:0]    write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic [WIDTH-1:0] read1_data,
  output logic [WIDTH-1:0] read2_data,
  output logic             err
);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [NREGS-1:0] cell_en;
  logic [NREGS-1:0] cell_err;

  always_comb begin
    cell_en = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cell_en[i] = write_en & (write_reg == AW'(i));
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    register #(.WIDTH(WIDTH)) u_reg (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (cell_en[g]),
      .d_i   (write_data),
      .q_o   (rf_q[g]),
      .err_o (cell_err[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass1;
  logic bypass2;

  // Forwarding is held off during reset so reads reflect the register about to clear.
  always_comb begin
    bypass1    = write_en & ~rst & (read1_reg == write_reg);
    bypass2    = write_en & ~rst & (read2_reg == write_reg);
    read1_data = bypass1 ? write_data : rf_q[read1_reg];
    read2_data = bypass2 ? write_data : rf_q[read2_reg];
  end
`else
  always_comb begin
    read1_data = rf_q[read1_reg];
    read2_data = rf_q[read2_reg];
  end
`endif

  always_comb begin
    err = $isunknown({write_en, rst, clk, write_data, write_reg, read1_reg, read2_reg})
          | (|cell_err);
  end

endmodule
